// File: rtl/mul32u_seq.sv
// -----------------------------------------------------------------------------
// mul32u_seq -- sequential 32x32 unsigned shift-add multiplier (64-bit product)
//
// The multiplier b is scanned one bit per clock, LSB first. For every set bit
// the partial product {32'b0,a} << idx is added into a 64-bit accumulator. The
// partial product comes from a single shiftl64 instance.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   reset, asynchronous, active-high
//   in_valid   in   1   operands a/b valid
//   in_ready   out  1   operands can be accepted (IDLE only)
//   a          in  32   multiplicand (shifted)
//   b          in  32   multiplier (scanned)
//   out_valid  out  1   product valid (DONE)
//   out_ready  in   1   consumer accepts product
//   product    out 64   a*b, unsigned, registered
//   busy       out  1   high in RUN or DONE
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_valid is only sampled in IDLE; the upstream must hold it
// until in_ready is seen. out_valid/product stay stable until out_ready.
//
// Configuration
//   MUL32U_EARLY_EXIT_EN  when defined, RUN ends as soon as no set bits of b
//                         remain above the current index; product unchanged.
//
// The FSM state is held in the 'state' signal (IDLE/RUN/DONE) for probing.
// -----------------------------------------------------------------------------

module shiftl64 (
    input  logic [7:0]  n,
    input  logic [63:0] x,
    output logic [63:0] y
);
    // Shift amounts of 64 or more clear the result.
    assign y = (n >= 8'd64) ? 64'd0 : (x << n[5:0]);
endmodule

module mul32u_seq #(
    parameter int W     = 32,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [2*W-1:0]     acc;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [2*W-1:0]     pp;
    logic               last;

    shiftl64 u_shift (
        .n (idx),
        .x ({{W{1'b0}}, a_q}),
        .y (pp)
    );

`ifdef MUL32U_EARLY_EXIT_EN
    // Stop once every remaining higher bit of the multiplier is zero.
    assign last = ((b_q >> (idx + 1'b1)) == {W{1'b0}});
`else
    assign last = (idx == IDX_W'(W - 1));
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // in_valid is ignored here; a new accept waits for IDLE.
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand latches, bit index and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            idx <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                RUN: begin
                    if (b_q[idx[4:0]]) acc <= acc + pp;
                    idx <= idx + 1'b1;
                end
                default: begin
                    // DONE holds; acc stays visible until the next accept.
                end
            endcase
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_mul32u_seq.sv
// -----------------------------------------------------------------------------
// tb_mul32u_seq -- directed testbench for mul32u_seq.
// Build with +define+MUL32U_EARLY_EXIT_EN to check the early-exit latencies.
// -----------------------------------------------------------------------------

module tb_mul32u_seq;

`ifdef MUL32U_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mul32u_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Clock: rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // All driving and sampling happens 1 time unit after a rising edge.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;     // E0: accept
        in_valid = 1'b0;
    endtask

    // Counts edges after E0 until out_valid is seen; 100 means timeout.
    task automatic wait_done(output int lat);
        lat = 100;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic finish_op;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int lat;
        rst = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 64'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: in_ready=%b out_valid=%b product=%h busy=%b, required 1 0 0 0",
                     in_ready, out_valid, product, busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        start_op(32'd3, 32'd3);
        wait_done(lat);
        checks++;
        if (product !== 64'd9) begin
            errors++;
            $display("FAIL reset_pre_product: got %h required %h", product, 64'd9);
        end
        // Asynchronous pulse between clock edges while sitting in DONE.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 64'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: in_ready=%b out_valid=%b product=%h busy=%b, required 1 0 0 0",
                     in_ready, out_valid, product, busy);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_identity;
        int lat;
        int exp_lat;
        exp_lat = EARLY ? 17 : 32;
        start_op(32'h0001_0000, 32'h0001_0000);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL identity_run_flags: busy=%b in_ready=%b, required 1 0", busy, in_ready);
        end
        wait_done(lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL identity_latency: got %0d edges required %0d", lat, exp_lat);
        end
        checks++;
        if (product !== 64'h0000_0001_0000_0000) begin
            errors++;
            $display("FAIL identity_product: got %h required %h", product, 64'h0000_0001_0000_0000);
        end
        finish_op();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL identity_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_maximum;
        int lat;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("FAIL maximum_latency: got %0d edges required %0d", lat, 32);
        end
        checks++;
        if (product !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL maximum_product: got %h required %h", product, 64'hFFFF_FFFE_0000_0001);
        end
        finish_op();
    endtask

    task automatic test_backpressure;
        int lat;
        int exp_lat;
        exp_lat = EARLY ? 3 : 32;
        start_op(32'd7, 32'd6);
        wait_done(lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL backpressure_latency: got %0d edges required %0d", lat, exp_lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || product !== 64'd42 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d: out_valid=%b product=%h in_ready=%b, required 1 %h 0",
                         i, out_valid, product, in_ready, 64'd42);
            end
        end
        finish_op();
        checks++;
        if (product !== 64'd42 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_after: product=%h out_valid=%b, required %h 0",
                     product, out_valid, 64'd42);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        int exp_lat;
        int stale;
        exp_lat = EARLY ? 4 : 32;
        start_op(32'd3, 32'd5);
        repeat (9) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b in_ready=%b out_valid=%b, required 0 1 0",
                     busy, in_ready, out_valid);
        end
        #2 rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL midrun_stale: got %0d active cycles required 0", stale);
        end
        start_op(32'd2, 32'd9);
        wait_done(lat);
        checks++;
        if (lat !== exp_lat || product !== 64'd18) begin
            errors++;
            $display("FAIL midrun_next: latency=%0d product=%h, required %0d %h",
                     lat, product, exp_lat, 64'd18);
        end
        finish_op();
    endtask

    task automatic test_zero_operands;
        int lat;
        int exp_lat;
        exp_lat = EARLY ? 29 : 32;
        start_op(32'd0, 32'h1234_5678);
        wait_done(lat);
        checks++;
        if (lat !== exp_lat || product !== 64'd0) begin
            errors++;
            $display("FAIL zero_a: latency=%0d product=%h, required %0d 0", lat, product, exp_lat);
        end
        finish_op();
        exp_lat = EARLY ? 1 : 32;
        start_op(32'hDEAD_BEEF, 32'd0);
        wait_done(lat);
        checks++;
        if (lat !== exp_lat || product !== 64'd0) begin
            errors++;
            $display("FAIL zero_b: latency=%0d product=%h, required %0d 0", lat, product, exp_lat);
        end
        finish_op();
        start_op(32'h0000_0005, 32'h8000_0000);
        wait_done(lat);
        checks++;
        if (lat !== 32 || product !== 64'h0000_0002_8000_0000) begin
            errors++;
            $display("FAIL top_bit_b: latency=%0d product=%h, required 32 %h",
                     lat, product, 64'h0000_0002_8000_0000);
        end
        finish_op();
    endtask

    task automatic test_ignore_inputs;
        int lat;
        int busy_bad;
        start_op(32'd3, 32'h8000_0001);
        busy_bad = 0;
        // Garbage on the operand ports, in_valid and early out_ready during RUN.
        a         = 32'hFFFF_FFFF;
        b         = 32'hFFFF_FFFF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) busy_bad++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL ignore_run_flags: got %0d bad cycles required 0", busy_bad);
        end
        wait_done(lat);
        lat = lat + 5;
        checks++;
        if (lat !== 32 || product !== 64'h0000_0001_8000_0003) begin
            errors++;
            $display("FAIL ignore_result: latency=%0d product=%h, required 32 %h",
                     lat, product, 64'h0000_0001_8000_0003);
        end
        finish_op();
    endtask

    task automatic test_done_collision;
        int lat;
        int exp_lat;
        start_op(32'h10, 32'h11);
        wait_done(lat);
        checks++;
        if (product !== 64'h110) begin
            errors++;
            $display("FAIL collision_first: got %h required %h", product, 64'h110);
        end
        // Both handshakes requested in DONE: only the output side completes.
        a         = 32'd5;
        b         = 32'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 64'h110) begin
            errors++;
            $display("FAIL collision_idle: in_ready=%b out_valid=%b busy=%b product=%h, required 1 0 0 %h",
                     in_ready, out_valid, busy, product, 64'h110);
        end
        @(posedge clk); #1;     // accept in IDLE
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL collision_accept: busy=%b in_ready=%b, required 1 0", busy, in_ready);
        end
        exp_lat = EARLY ? 2 : 32;
        wait_done(lat);
        checks++;
        if (lat !== exp_lat || product !== 64'd15) begin
            errors++;
            $display("FAIL collision_second: latency=%0d product=%h, required %0d %h",
                     lat, product, exp_lat, 64'd15);
        end
        finish_op();
    endtask

    task automatic test_back_to_back;
        int lat;
        int exp_lat;
        // out_ready held high: out_valid lasts one cycle, then immediate re-accept.
        out_ready = 1'b1;
        exp_lat = EARLY ? 15 : 32;
        start_op(32'h1234, 32'h5678);
        wait_done(lat);
        checks++;
        if (lat !== exp_lat || product !== 64'h0626_0060) begin
            errors++;
            $display("FAIL b2b_first: latency=%0d product=%h, required %0d %h",
                     lat, product, exp_lat, 64'h0626_0060);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 64'h0626_0060) begin
            errors++;
            $display("FAIL b2b_single_cycle: out_valid=%b in_ready=%b product=%h, required 0 1 %h",
                     out_valid, in_ready, product, 64'h0626_0060);
        end
        exp_lat = EARLY ? 1 : 32;
        start_op(32'hFFFF_FFFF, 32'd1);
        wait_done(lat);
        checks++;
        if (lat !== exp_lat || product !== 64'h0000_0000_FFFF_FFFF) begin
            errors++;
            $display("FAIL b2b_second: latency=%0d product=%h, required %0d %h",
                     lat, product, exp_lat, 64'h0000_0000_FFFF_FFFF);
        end
        @(posedge clk); #1;
        start_op(32'h8000_0000, 32'h8000_0000);
        wait_done(lat);
        checks++;
        if (lat !== 32 || product !== 64'h4000_0000_0000_0000) begin
            errors++;
            $display("FAIL b2b_third: latency=%0d product=%h, required 32 %h",
                     lat, product, 64'h4000_0000_0000_0000);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_identity();
        test_maximum();
        test_backpressure();
        test_reset_mid_run();
        test_zero_operands();
        test_ignore_inputs();
        test_done_collision();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
